axis_uart: RTL and testbench

AXIS_UART -- requirements
Module: axis_uart

---
 rtl/axis_uart.sv | 181 ++++++++++++++++++
 tb/tb_axis_uart.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart.sv
// axis_uart: 8N1 UART bridging AXI-Stream byte streams to an RS-232 line pair.
// Transmitter and receiver are independent FSMs sharing only the clock and reset.
module axis_uart #(
    parameter int CLOCK_FREQ = 10_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    output logic       txd,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready
);
    localparam int BIT_CYCLES = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CNT_W      = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             txd_q, txd_d;
    logic             s_tready_q, s_tready_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        s_tready_d = s_tready_q;
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d   = '0;
                txd_d      = 1'b1;
                s_tready_d = 1'b1;
                if (s_tvalid && s_tready_q) begin
                    tx_shift_d = s_tdata;
                    s_tready_d = 1'b0;
                    txd_d      = 1'b0;
                    tx_state_d = START;
                end
            end
            START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_state_d = DATA;
                end
            end
            DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end
            end
            STOP: begin
                // Ready rises as the stop bit ends, so the next byte can start one cycle later.
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    s_tready_d = 1'b1;
                    tx_state_d = IDLE;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            s_tready_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            s_tready_q <= s_tready_d;
        end
    end

    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    state_t           rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       m_tdata_q, m_tdata_d;
    logic             m_tvalid_q, m_tvalid_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q && !m_tready;
        case (rx_state_q)
            IDLE: begin
                // Requiring a 1->0 transition also holds off re-arming after a framing error.
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_state_d = START;
            end
            START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = STOP;
                    else                  rx_bit_d   = rx_bit_q + 1'b1;
                end
            end
            STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = IDLE;
                    if (rx_s2_q) begin
                        m_tdata_d  = rx_shift_q;
                        m_tvalid_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
        end else begin
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
        end
    end

    assign txd      = txd_q;
    assign s_tready = s_tready_q;
    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
endmodule

// File: tb/tb_axis_uart.sv
// Scoreboard bench for axis_uart: queued expected bytes, independent TX line and RX stream monitors.
module tb_axis_uart;
    localparam int BIT = 87;

    logic       clk = 1'b0;
    logic       resetn, rxd, txd, s_tvalid, s_tready, m_tvalid, m_tready;
    logic [7:0] s_tdata, m_tdata;
    logic       rxd_drv, loop_en, tx_mon_en;

    always #5 clk = ~clk;
    assign rxd = loop_en ? txd : rxd_drv;

    axis_uart dut (
        .clk(clk), .resetn(resetn), .rxd(rxd), .txd(txd),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Line monitor: every frame on txd must match the next queued byte, bit by bit and cycle by cycle.
    initial begin : tx_mon
        logic [9:0] frame;
        logic [7:0] b;
        int         bad;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && tx_mon_en && txd === 1'b0) begin
                if (tx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected_frame: start bit seen, no byte queued");
                    b = 8'h00;
                end else begin
                    b = tx_exp.pop_front();
                end
                frame = {1'b1, b, 1'b0};
                for (int k = 0; k < 10; k++) begin
                    bad = 0;
                    for (int c = 0; c < BIT; c++) begin
                        if (!(k == 0 && c == 0)) @(negedge clk);
                        if (txd !== frame[k]) bad++;
                    end
                    check($sformatf("tx_%02h_bit%0d_wrong_cycles", b, k), bad, 0);
                end
            end
        end
    end

    // Stream monitor: each accepted master beat pops the scoreboard.
    initial begin : rx_mon
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
                if (rx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected_byte: got 0x%02h, required none", m_tdata);
                end else begin
                    check("rx_byte", m_tdata, rx_exp.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit push);
        int n = 0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        if (push) tx_exp.push_back(b);
        forever begin
            @(negedge clk);
            if (s_tready === 1'b1) break;
            n++;
            if (n > 3000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: s_tready=0, required 1 within 3000 cycles");
                break;
            end
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tdata  = 8'($urandom);
    endtask

    task automatic drive_bits(input logic [9:0] f, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            rxd_drv = f[k];
            repeat (BIT) @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop);
        drive_bits({stop, b, 1'b0}, 0, 9);
        rxd_drv = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (rx_exp.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, rx_exp.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic count_valid(input string name, input int cycles);
        int hi = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (m_tvalid !== 1'b0) hi++;
        end
        check(name, hi, 0);
        @(posedge clk); #1;
    endtask

    initial begin : stim
        int         n;
        logic [7:0] b;
        resetn = 1'b0; rxd_drv = 1'b1; loop_en = 1'b0; tx_mon_en = 1'b1;
        s_tvalid = 1'b0; s_tdata = 8'h00; m_tready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_txd", txd, 1);
        check("reset_s_tready", s_tready, 0);
        check("reset_m_tvalid", m_tvalid, 0);
        check("reset_m_tdata", m_tdata, 0);
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk) check("s_tready_before_first_edge", s_tready, 0);
        @(negedge clk) check("s_tready_after_first_edge", s_tready, 1);

        // Single-cycle reset pulse.
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        check("pulse_txd", txd, 1);
        check("pulse_m_tvalid", m_tvalid, 0);
        check("pulse_s_tready", s_tready, 0);
        @(negedge clk) check("pulse_s_tready_next", s_tready, 1);
        @(posedge clk); #1;

        // 0xA5 on the line, and ready held low for the whole frame.
        send_byte(8'hA5, 1'b1);
        n = 0;
        forever begin
            @(negedge clk);
            if (s_tready === 1'b1 || n > 2000) break;
            n++;
        end
        check("a5_s_tready_low_cycles", n, 10 * BIT);
        @(posedge clk); #1;
        repeat (10) @(posedge clk); #1;

        // 0x3C received: not valid before the stop bit, valid after it, held until accepted.
        m_tready = 1'b0;
        drive_bits({1'b1, 8'h3C, 1'b0}, 0, 8);
        @(negedge clk) check("3c_no_valid_before_stop", m_tvalid, 0);
        @(posedge clk); #1;
        drive_bits({1'b1, 8'h3C, 1'b0}, 9, 9);
        @(negedge clk);
        check("3c_valid", m_tvalid, 1);
        check("3c_data", m_tdata, 8'h3C);
        repeat (20) @(negedge clk);
        check("3c_held_valid", m_tvalid, 1);
        check("3c_held_data", m_tdata, 8'h3C);
        rx_exp.push_back(8'h3C);
        @(posedge clk); #1 m_tready = 1'b1;
        @(posedge clk); #1 m_tready = 1'b0;
        @(negedge clk) check("3c_clear_after_handshake", m_tvalid, 0);
        check("3c_consumed", rx_exp.size(), 0);
        @(posedge clk); #1 m_tready = 1'b1;

        // Loopback, back-to-back.
        loop_en = 1'b1;
        foreach (tx_exp[i]) b = tx_exp[i];
        rx_exp.push_back(8'h00); send_byte(8'h00, 1'b1);
        rx_exp.push_back(8'hFF); send_byte(8'hFF, 1'b1);
        rx_exp.push_back(8'h55); send_byte(8'h55, 1'b1);
        drain("loop_drain", 4 * 10 * BIT);
        loop_en = 1'b0;

        // Short glitch, then a frame with a bad stop bit; neither may produce a byte.
        m_tready = 1'b0;
        rxd_drv = 1'b0;
        repeat (20) @(posedge clk); #1;
        rxd_drv = 1'b1;
        count_valid("glitch_no_valid", 3 * BIT);
        drive_rx(8'h81, 1'b0);
        repeat (2 * BIT) @(posedge clk); #1;
        @(negedge clk) check("framing_no_valid", m_tvalid, 0);
        @(posedge clk); #1;
        m_tready = 1'b1;
        rx_exp.push_back(8'h6B);
        drive_rx(8'h6B, 1'b1);
        drain("after_framing_drain", 3 * BIT);

        // Overrun: second byte replaces the first.
        m_tready = 1'b0;
        drive_rx(8'h12, 1'b1);
        repeat (BIT) @(posedge clk); #1;
        @(negedge clk);
        check("overrun_first_valid", m_tvalid, 1);
        check("overrun_first_data", m_tdata, 8'h12);
        @(posedge clk); #1;
        drive_rx(8'hC7, 1'b1);
        repeat (BIT) @(posedge clk); #1;
        @(negedge clk);
        check("overrun_valid", m_tvalid, 1);
        check("overrun_data", m_tdata, 8'hC7);
        @(posedge clk); #1;
        rx_exp.push_back(8'hC7);
        m_tready = 1'b1;
        drain("overrun_drain", 10);
        @(negedge clk) check("overrun_cleared", m_tvalid, 0);
        @(posedge clk); #1;

        // Reset in the middle of a transmitted frame (0xE1: line is in data bit 2, low).
        tx_mon_en = 1'b0;
        send_byte(8'hE1, 1'b0);
        repeat (300) @(posedge clk); #1;
        @(negedge clk) check("midtx_line_low", txd, 0);
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        check("midtx_reset_txd", txd, 1);
        check("midtx_reset_s_tready", s_tready, 0);
        n = 0;
        for (int i = 0; i < 10 * BIT; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) n++;
        end
        check("midtx_aborted_low_cycles", n, 0);
        check("midtx_ready_back", s_tready, 1);
        tx_mon_en = 1'b1;
        @(posedge clk); #1;

        // Random loopback bytes with random gaps.
        loop_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            rx_exp.push_back(b);
            send_byte(b, 1'b1);
            repeat ($urandom_range(0, 150)) @(posedge clk);
            #1;
        end
        drain("rand_loop_drain", 3 * 10 * BIT);
        loop_en = 1'b0;

        // Random bytes driven straight onto rxd.
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            rx_exp.push_back(b);
            drive_rx(b, 1'b1);
            repeat ($urandom_range(1, 100)) @(posedge clk);
            #1;
        end
        drain("rand_rx_drain", 2 * BIT);

        repeat (20) @(posedge clk);
        check("tx_queue_empty", tx_exp.size(), 0);
        check("rx_queue_empty", rx_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
